locked_adder_query_monitor: RTL

Sequential query engine that sits on both sides of the 32-bit key-locked adder under partial-key simulation. It drives pseudo-random operands into the adder's `add1_i`/`add2_i` and consumes its 33-bit `result_o`, comparing each result against an internal golden sum. It accumulates error statistics (mismatching queries, total and maximum Hamming distance, first failing query) over a fixed run, so a candidate key can be scored in hardware.

---
 rtl/locked_adder_pkg.sv | 15 +
 rtl/popcount33.sv | 12 +
 rtl/locked_adder_query_monitor.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/locked_adder_pkg.sv
// rtl/locked_adder_pkg.sv - shared widths, LFSR taps and FSM type for the locked-adder query monitor
package locked_adder_pkg;
  localparam int ADD_W  = 32;
  localparam int RES_W  = 33;
  localparam int LFSR_W = 64;
  localparam int HD_W   = 6;
  // Feedback taps at bits 63, 62, 60, 59 (polynomial x^64 + x^63 + x^61 + x^60 + 1)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} qm_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/popcount33.sv
// rtl/popcount33.sv - combinational population count of a 33-bit word
module popcount33
  import locked_adder_pkg::*;
(
  input  logic [RES_W-1:0] din_i,
  output logic [HD_W-1:0]  cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < RES_W; i++) cnt_o = cnt_o + HD_W'(din_i[i]);
  end
endmodule

// File: rtl/locked_adder_query_monitor.sv
// rtl/locked_adder_query_monitor.sv - drives LFSR queries into a locked adder and scores its results
module locked_adder_query_monitor
  import locked_adder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int N_QUERIES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [63:0]      seed_i,
  output logic [WIDTH-1:0] add1_o,
  output logic [WIDTH-1:0] add2_o,
  input  logic [WIDTH:0]   result_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      mismatch_cnt_o,
  output logic [31:0]      hd_sum_o,
  output logic [HD_W-1:0]  hd_max_o,
  output logic [23:0]      first_fail_o,
  output logic             first_fail_vld_o
);
  qm_state_t         state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [23:0]       qcnt_q, qcnt_d;
  logic              cap_vld_q, cap_vld_d;
  logic [HD_W-1:0]   cap_hd_q, cap_hd_d;
  logic [23:0]       cap_idx_q, cap_idx_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [31:0]       mis_q, mis_d, hds_q, hds_d;
  logic [HD_W-1:0]   hdm_q, hdm_d;
  logic [23:0]       ff_q, ff_d;
  logic              ffv_q, ffv_d;

  logic [RES_W-1:0]  golden;
  logic [HD_W-1:0]   hd;
  logic [32:0]       hd_sum_ext;

  assign add1_o  = lfsr_q[WIDTH-1:0];
  assign add2_o  = lfsr_q[2*WIDTH-1:WIDTH];
  assign golden  = {1'b0, add1_o} + {1'b0, add2_o};

  popcount33 u_popcount (
    .din_i (result_i ^ golden),
    .cnt_o (hd)
  );

  assign hd_sum_ext = {1'b0, hds_q} + {27'b0, cap_hd_q};

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    qcnt_d    = qcnt_q;
    cap_vld_d = 1'b0;
    cap_hd_d  = cap_hd_q;
    cap_idx_d = cap_idx_q;
    busy_d    = busy_q;
    done_d    = done_q;
    mis_d     = mis_q;
    hds_d     = hds_q;
    hdm_d     = hdm_q;
    ff_d      = ff_q;
    ffv_d     = ffv_q;

    // Second pipeline stage: fold the captured query into the statistics
    if (cap_vld_q) begin
      if (cap_hd_q != '0 && mis_q != '1) mis_d = mis_q + 32'd1;
      hds_d = hd_sum_ext[32] ? '1 : hd_sum_ext[31:0];
      if (cap_hd_q > hdm_q) hdm_d = cap_hd_q;
      if (cap_hd_q != '0 && !ffv_q) begin
        ff_d  = cap_idx_q;
        ffv_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_RUN;
          lfsr_d  = (seed_i == '0) ? 64'h1 : seed_i;
          qcnt_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          mis_d   = '0;
          hds_d   = '0;
          hdm_d   = '0;
          ff_d    = '0;
          ffv_d   = 1'b0;
        end
      end
      ST_RUN: begin
        cap_vld_d = 1'b1;
        cap_hd_d  = hd;
        cap_idx_d = qcnt_q;
        lfsr_d    = lfsr_next(lfsr_q);
        qcnt_d    = qcnt_q + 24'd1;
        if (qcnt_q == 24'(N_QUERIES - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= 64'h1;
      qcnt_q    <= '0;
      cap_vld_q <= 1'b0;
      cap_hd_q  <= '0;
      cap_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mis_q     <= '0;
      hds_q     <= '0;
      hdm_q     <= '0;
      ff_q      <= '0;
      ffv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      qcnt_q    <= qcnt_d;
      cap_vld_q <= cap_vld_d;
      cap_hd_q  <= cap_hd_d;
      cap_idx_q <= cap_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mis_q     <= mis_d;
      hds_q     <= hds_d;
      hdm_q     <= hdm_d;
      ff_q      <= ff_d;
      ffv_q     <= ffv_d;
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign mismatch_cnt_o   = mis_q;
  assign hd_sum_o         = hds_q;
  assign hd_max_o         = hdm_q;
  assign first_fail_o     = ff_q;
  assign first_fail_vld_o = ffv_q;
endmodule
